// File: rtl/ahb_bram_pkg.sv
// rtl/ahb_bram_pkg.sv - shared AHB encodings and controller state for the BRAM slave
package ahb_bram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bram_strb.sv
// rtl/ahb_bram_strb.sv - HSIZE/HADDR[1:0] to byte-lane strobe decoder with misalignment flag
module ahb_bram_strb
  import ahb_bram_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misaligned
);

  // Anything wider than a word still writes all four lanes; it is only flagged.
  always_comb begin
    strb       = 4'b1111;
    misaligned = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// rtl/ahb_bram_ctrl.sv - AHB-Lite slave sequencing a 1-cycle-latency byte-lane BRAM
// Optional: define AHB_BRAM_ERR_EN to answer misaligned/oversized accesses with a two-cycle ERROR.
module ahb_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          ram_cs,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]    wr_strb_q, wr_strb_d;
  logic [3:0]    strb;
  logic          misaligned;
  logic          accept;
  logic          err_acc;
  logic          cs_int;
  logic [3:0]    we_int;
  logic          resp_int;

  ahb_bram_strb u_strb (
    .size       (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .strb       (strb),
    .misaligned (misaligned)
  );

  assign accept = HSEL & HREADY & htrans_active(HTRANS);

`ifdef AHB_BRAM_ERR_EN
  logic unused_bits;
  assign unused_bits = ^HADDR[31:AW+2];
  assign err_acc     = misaligned;
  assign HRESP       = resp_int;
`else
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:AW+2], misaligned, resp_int};
  assign err_acc     = 1'b0;
  assign HRESP       = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_strb_q <= '0;
    end else begin
      state     <= state_nxt;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_strb_d = wr_strb_q;
    cs_int    = 1'b0;
    we_int    = 4'b0000;
    ram_addr  = HADDR[AW+1:2];
    HREADYOUT = 1'b1;
    resp_int  = 1'b0;

    case (state)
      ST_WR: begin
        cs_int   = 1'b1;
        we_int   = wr_strb_q;
        ram_addr = wr_addr_q;
      end
      ST_RD_STALL: begin
        cs_int    = 1'b1;
        ram_addr  = rd_addr_q;
        HREADYOUT = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        resp_int  = 1'b1;
      end
      ST_ERR2: resp_int = 1'b1;
      default: ;
    endcase

    // A read landing on a write data phase must wait: the port is busy with the write.
    if (state == ST_RD_STALL) begin
      state_nxt = ST_RD;
    end else if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (accept) begin
      if (err_acc) begin
        state_nxt = ST_ERR1;
      end else if (HWRITE) begin
        wr_addr_d = HADDR[AW+1:2];
        wr_strb_d = strb;
        state_nxt = ST_WR;
      end else if (state == ST_WR) begin
        rd_addr_d = HADDR[AW+1:2];
        state_nxt = ST_RD_STALL;
      end else begin
        cs_int    = 1'b1;
        ram_addr  = HADDR[AW+1:2];
        state_nxt = ST_RD;
      end
    end
  end

  assign ram_cs    = cs_int & HRESETn;
  assign ram_we    = we_int & {4{HRESETn}};
  assign ram_wdata = HWDATA;
  assign HRDATA    = ram_rdata;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb/tb_ahb_bram_ctrl.sv - randomized bench for ahb_bram_ctrl against a byte-array memory model
module tb_ahb_bram_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic          ram_cs;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_bram_ctrl #(.AW(AW)) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) bram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= bram[ram_addr];
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    int          gap;
  } txn_t;

  logic [7:0]  ref_mem [0:4*(1<<AW)-1];
  txn_t        txq[$];
  logic [31:0] rd_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return i * 32'h9E3779B9 + 32'h1357_0000;
  endfunction

  function automatic int nbytes(input logic [2:0] size);
    return (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input txn_t t);
`ifdef AHB_BRAM_ERR_EN
    return (t.size > 3'd2) || ((int'(t.addr[1:0]) % nbytes(t.size)) != 0);
`else
    return (t.size > 3'd7);
`endif
  endfunction

  // Lanes covered: the naturally aligned block of nbytes containing the address.
  function automatic logic [3:0] model_strb(input txn_t t);
    int n = nbytes(t.size);
    int first = (int'(t.addr[1:0]) / n) * n;
    logic [3:0] s = 4'b0000;
    for (int k = 0; k < 4; k++)
      if (k >= first && k < first + n) s[k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int base = int'(addr[AW+1:2]) * 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic void model_write(input txn_t t);
    logic [3:0] s = model_strb(t);
    int base = int'(t.addr[AW+1:2]) * 4;
    for (int k = 0; k < 4; k++)
      if (s[k]) ref_mem[base+k] = t.data[8*k +: 8];
  endfunction

  task automatic push(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] data, input int gap);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.data = data; t.gap = gap;
    txq.push_back(t);
  endtask

  task automatic drive_idle();
    hsel   = 1'($urandom_range(0, 1));
    htrans = 2'($urandom_range(0, 1));
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'($urandom_range(0, 2));
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Pipelined master: one address phase overlapping the previous data phase.
  task automatic run_seq();
    txn_t dp, ap;
    bit dp_v = 1'b0;
    bit ap_v, prev_wr, rdy, resp_s, cs_s;
    int waits = 0, exp_wait = 0;
    logic [31:0] rdata_s, wdata_s;
    logic [3:0] we_s;
    logic [AW-1:0] addr_s;
    while (txq.size() > 0 || dp_v) begin
      ap_v = 1'b0;
      if (txq.size() > 0 && txq[0].gap > 0) begin
        ap = txq[0]; ap.gap--; txq[0] = ap;
        drive_idle();
      end else if (txq.size() > 0) begin
        ap = txq[0]; ap_v = 1'b1;
        hsel = 1'b1; htrans = 2'b10; haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
      end else begin
        drive_idle();
      end
      hwdata = (dp_v && dp.wr) ? dp.data : $urandom;
      prev_wr = dp_v && dp.wr && !is_err(dp);

      @(negedge clk);
      rdy = hreadyout; resp_s = hresp; rdata_s = hrdata; cs_s = ram_cs;
      we_s = ram_we; addr_s = ram_addr; wdata_s = ram_wdata;
      if (dp_v && !rdy) begin
        stall_cnt++;
        check_eq("wait_resp", 32'(resp_s), 32'(is_err(dp)));
        if (is_err(dp)) check_eq("err_cs", 32'(cs_s), 32'd0);
      end
      if (dp_v && rdy && prev_wr) begin
        check_eq("wr_we", 32'(we_s), 32'(model_strb(dp)));
        check_eq("wr_cs", 32'(cs_s), 32'd1);
        check_eq("wr_addr", 32'(addr_s), 32'(dp.addr[AW+1:2]));
        check_eq("wr_data", wdata_s, dp.data);
      end
      if (ap_v && rdy && !ap.wr && !is_err(ap) && !prev_wr) begin
        check_eq("rd_cs", 32'(cs_s), 32'd1);
        check_eq("rd_addr", 32'(addr_s), 32'(ap.addr[AW+1:2]));
        check_eq("rd_we", 32'(we_s), 32'd0);
      end

      @(posedge clk); #1;
      if (rdy) begin
        if (dp_v) begin
          check_eq("waits", 32'(waits), 32'(exp_wait));
          check_eq("resp", 32'(resp_s), 32'(is_err(dp)));
          if (!is_err(dp)) begin
            if (dp.wr) model_write(dp);
            else begin
              check_eq("rdata", rdata_s, model_word(dp.addr));
              rd_log.push_back(rdata_s);
            end
          end
          dp_v = 1'b0;
        end
        if (ap_v) begin
          exp_wait = (is_err(ap) || (!ap.wr && prev_wr)) ? 1 : 0;
          dp = ap; dp_v = 1'b1; waits = 0;
          void'(txq.pop_front());
        end
      end else begin
        waits++;
        if (waits > 8) begin
          n_bad++;
          $display("FAIL timeout: HREADYOUT low for %0d cycles, expected at most 1", waits);
          finish_run();
        end
      end
    end
  endtask

  initial begin
    txn_t t;
    int w, lane;
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i] = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_word(i) >> (8*k);
    end
    drive_idle();
    hwdata = 32'h0;

    // Reset values, then reset asserted during a write data phase to 0x10
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(hreadyout), 32'd1);
    check_eq("rst_resp", 32'(hresp), 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    check_eq("rst_cs", 32'(ram_cs), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_we", 32'(ram_we), 32'd0);
    check_eq("midrst_cs", 32'(ram_cs), 32'd0);
    check_eq("midrst_ready", 32'(hreadyout), 32'd1);
    check_eq("midrst_resp", 32'(hresp), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_we", 32'(ram_we), 32'd0);
    check_eq("postrst_ready", 32'(hreadyout), 32'd1);
    rd_log.delete();
    push(1'b0, 32'h10, 3'd2, 32'h0, 0);
    run_seq();
    check_eq("w10_unchanged", rd_log[0], init_word(4));

    // Word write then separated read: no wait state
    rd_log.delete(); stall_cnt = 0;
    push(1'b1, 32'h4, 3'd2, 32'hDEADBEEF, 0);
    push(1'b0, 32'h4, 3'd2, 32'h0, 1);
    run_seq();
    check_eq("w4_word", rd_log[0], 32'hDEADBEEF);
    check_eq("w4_stalls", 32'(stall_cnt), 32'd0);

    // Byte and halfword writes
    rd_log.delete();
    push(1'b1, 32'h6, 3'd0, 32'h00AA0000, 0);
    push(1'b1, 32'h8, 3'd1, 32'h00001234, 0);
    push(1'b0, 32'h4, 3'd2, 32'h0, 1);
    push(1'b0, 32'h8, 3'd2, 32'h0, 0);
    run_seq();
    check_eq("byte_merge", rd_log[0], 32'hDEAABEEF);
    check_eq("half_low", {16'h0, rd_log[1][15:0]}, 32'h00001234);

    // Write immediately followed by read of the same word: one wait state
    rd_log.delete(); stall_cnt = 0;
    push(1'b1, 32'h20, 3'd2, 32'h00000055, 0);
    push(1'b0, 32'h20, 3'd2, 32'h0, 0);
    run_seq();
    check_eq("raw_data", rd_log[0], 32'h00000055);
    check_eq("raw_stalls", 32'(stall_cnt), 32'd1);

    // Back-to-back reads
    rd_log.delete(); stall_cnt = 0;
    push(1'b0, 32'h0, 3'd2, 32'h0, 1);
    push(1'b0, 32'h4, 3'd2, 32'h0, 0);
    push(1'b0, 32'h8, 3'd2, 32'h0, 0);
    run_seq();
    check_eq("b2b_stalls", 32'(stall_cnt), 32'd0);
    check_eq("b2b_r0", rd_log[0], init_word(0));
    check_eq("b2b_r1", rd_log[1], 32'hDEAABEEF);

    // Misaligned word read at 0x2
    rd_log.delete(); stall_cnt = 0;
    push(1'b0, 32'h2, 3'd2, 32'h0, 1);
    run_seq();
`ifdef AHB_BRAM_ERR_EN
    check_eq("mis_stalls", 32'(stall_cnt), 32'd1);
    check_eq("mis_nodata", 32'(rd_log.size()), 32'd0);
`else
    check_eq("mis_stalls", 32'(stall_cnt), 32'd0);
    check_eq("mis_word0", rd_log[0], init_word(0));
`endif

    // Random traffic over a small window with aliased upper address bits
    for (int n = 0; n < 400; n++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.size = 3'($urandom_range(0, 2));
      w = $urandom_range(0, 31);
      lane = $urandom_range(0, 3);
      if (t.size == 3'd1) lane = lane & 2;
      if (t.size == 3'd2) lane = 0;
      t.addr = $urandom;
      t.addr[AW+1:0] = {AW'(w), 2'(lane)};
      t.data = $urandom;
      t.gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      txq.push_back(t);
    end
    run_seq();

    finish_run();
  end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave controller that sequences a single-port, byte-lane BRAM with 1-cycle registered-address read latency and per-byte write enables. Converts AHB address/data phases into BRAM cs/we/addr/wdata cycles. Returns zero-wait reads and zero-wait writes. Inserts exactly one wait state when a read address phase collides with an in-flight write data phase. Sits between the Cortex-M0 bus matrix and the code/data BRAM.

Parameters:
AW, 12, BRAM word-address width; byte address uses HADDR[AW+1:0].

Ports:
HCLK  in  1  clock; all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  0 byte, 1 halfword, 2 word
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus-level ready; address phase is accepted only when high
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  32  read data; passes ram_rdata straight through
ram_cs  out  1  BRAM chip select
ram_we  out  4  BRAM byte write enables
ram_addr  out  AW  BRAM word address
ram_wdata  out  32  BRAM write data
ram_rdata  in  32  BRAM read data, valid 1 cycle after cs/addr

Behaviour:
- Reset is asynchronous and active-low. The clock is HCLK and the reset is HRESETn.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, ram_we=0, ram_cs=0 (forced low while HRESETn=0), all pipeline registers 0.
- An access is accepted when HSEL & HTRANS[1] & HREADY, all at the same edge.
- Strobe decode:
  - HSIZE=0: we = 1<<HADDR[1:0].
  - HSIZE=1: we = HADDR[1] ? 4'b1100 : 4'b0011.
  - HSIZE>=2: we = 4'b1111.
- Word address: ram_addr = HADDR[AW+1:2]. Upper address bits are ignored (aliasing).
- States: IDLE, WR (write data phase), RD (read data phase), RD_STALL (deferred read issue), ERR1, ERR2.
- Read accepted in IDLE, RD or WR-with-no-conflict:
  - ram_cs=1 and ram_addr=HADDR combinationally in the address cycle.
  - Next state RD with HREADYOUT=1; HRDATA is valid that cycle, so zero wait.
- Write accepted:
  - Register word address and strobes; next state WR.
  - In WR: ram_cs=1, ram_we=registered strobes, ram_addr=registered address, ram_wdata=HWDATA, HREADYOUT=1.
- Conflict (read address phase accepted while in WR):
  - The BRAM port is busy, so register the read address; next state RD_STALL.
  - RD_STALL: HREADYOUT=0; issue ram_cs=1 with the registered address; next state RD. Exactly 1 wait state.
  - Because the write completes before the read issues, a write followed by a read of the same address returns the new data.
- Write following write: no conflict. The new write's address is registered while the previous write drives the BRAM.
- No accepted access (IDLE/BUSY/HSEL=0): next state IDLE, ram_cs=0, ram_we=0, HREADYOUT=1.
- While HREADYOUT=0, HREADY is low, so no new address phase is accepted.
- Reset mid-operation: any pending write or read is abandoned and the BRAM is not written.

Optional Feature:
AHB_BRAM_ERR_EN.
- Defined:
  - Misaligned accesses (HSIZE=1 with HADDR[0]=1, HSIZE=2 with HADDR[1:0]!=0) and HSIZE>2 go to ERR1 then ERR2.
  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1.
  - No BRAM cycle is issued for these accesses.
- Undefined:
  - HRESP is tied 0.
  - Misaligned accesses use the strobe decode above; HSIZE>2 is treated as a word.

Decomposition:
- Package ahb_bram_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE codes, and the state enum.
- One sub-module, ahb_bram_strb: combinational HSIZE/HADDR[1:0] to 4-bit strobe decoder, plus the misalignment flag.

Test Plan:
- Reset: HRESETn low mid-write to 0x10 -> HREADYOUT=1, HRESP=0, ram_we=0 during and after reset; word 0x10 unchanged.
- Word write 0x0000_0004 = 0xDEADBEEF, then word read 0x4 -> ram_we=4'b1111 in the write data phase; HRDATA=0xDEADBEEF with 0 wait states.
- Byte write 0xAA to 0x6, then halfword write 0x1234 to 0x8 -> ram_we=4'b0100 then 4'b0011; word 0x4 reads 0xDEAABEEF, word 0x8 low half 0x1234.
- Write 0x55 to word 0x20 immediately followed by a read of 0x20 -> exactly one cycle with HREADYOUT=0; read returns 0x00000055.
- Back-to-back NONSEQ reads of 0x0, 0x4, 0x8 -> HREADYOUT stays 1; data returned in order 1 cycle after each address phase.
- With AHB_BRAM_ERR_EN, word read at 0x2 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), ram_cs=0 throughout. Without it -> OKAY, reads word 0x0.
